clk_gen_sequencer: RTL and testbench

- Control sequencer for the clock-generation datapath.
- Accepts rate/duty/polarity configuration through a valid/ready port and derives the four rate-minus-N operands from it.
- Sequences polarity set, enable and drain of the generator.
- Applies configuration changes only on generated-clock edges, so waveforms never glitch; alternating high/low half rates gives PWM.

---
 rtl/clks_alot_p.sv | 30 +++
 rtl/common_p.sv | 9 +
 rtl/clk_rate_derive.sv | 45 ++++
 rtl/clk_gen_sequencer.sv | 167 ++++++++++++++++
 tb/tb_clk_gen_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/clks_alot_p.sv
// Types and defaults shared by the clock-generation control blocks.
package clks_alot_p;

  localparam int COUNTER_WIDTH = 16;
  localparam int MIN_HALF_RATE = 4;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN
  } seq_state_e;

  typedef struct packed {
    logic [COUNTER_WIDTH-1:0] high_half;
    logic [COUNTER_WIDTH-1:0] low_half;
    logic [COUNTER_WIDTH-1:0] preempt_lead;
    logic                     polarity;
  } rate_cfg_s;

  // The lead bound keeps the preemptive quarter operand from wrapping below zero.
  function automatic logic cfg_legal(input rate_cfg_s cfg,
                                     input logic [COUNTER_WIDTH-1:0] minHalf);
    logic [COUNTER_WIDTH-1:0] shortHalf;
    shortHalf = (cfg.high_half < cfg.low_half) ? cfg.high_half : cfg.low_half;
    return (cfg.high_half >= minHalf) && (cfg.low_half >= minHalf) &&
           (cfg.preempt_lead < (shortHalf >> 1));
  endfunction

endpackage

// File: rtl/common_p.sv
// Shared clock-domain bundle: one rising-edge clock with its synchronous active-low reset.
package common_p;

  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;

endpackage

// File: rtl/clk_rate_derive.sv
// Registered rate-minus-N operands for whichever half period (high or low) is in force.
module clk_rate_derive
  import clks_alot_p::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic                     level_i,
  input  rate_cfg_s                cfg_i,
  output logic [COUNTER_WIDTH-1:0] expected_half_rate_minus_two_o,
  output logic [COUNTER_WIDTH-1:0] expected_quarter_rate_minus_one_o,
  output logic [COUNTER_WIDTH-1:0] preemptive_half_rate_minus_one_o,
  output logic [COUNTER_WIDTH-1:0] preemptive_quarter_rate_minus_one_o
);

  logic [COUNTER_WIDTH-1:0] half;
  logic [COUNTER_WIDTH-1:0] quarter;
  logic [COUNTER_WIDTH-1:0] expHalf_q;
  logic [COUNTER_WIDTH-1:0] expQuarter_q;
  logic [COUNTER_WIDTH-1:0] preHalf_q;
  logic [COUNTER_WIDTH-1:0] preQuarter_q;

  assign half    = level_i ? cfg_i.high_half : cfg_i.low_half;
  assign quarter = half >> 1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      expHalf_q    <= '0;
      expQuarter_q <= '0;
      preHalf_q    <= '0;
      preQuarter_q <= '0;
    end else if (load_i) begin
      expHalf_q    <= half - COUNTER_WIDTH'(2);
      expQuarter_q <= quarter - COUNTER_WIDTH'(1);
      preHalf_q    <= half - COUNTER_WIDTH'(1);
      preQuarter_q <= quarter - COUNTER_WIDTH'(1) - cfg_i.preempt_lead;
    end
  end

  assign expected_half_rate_minus_two_o      = expHalf_q;
  assign expected_quarter_rate_minus_one_o   = expQuarter_q;
  assign preemptive_half_rate_minus_one_o    = preHalf_q;
  assign preemptive_quarter_rate_minus_one_o = preQuarter_q;

endmodule

// File: rtl/clk_gen_sequencer.sv
// Control sequencer for the clock generator: config intake, arm/run/drain sequencing, and
// glitch-free config swaps that only happen on generated-clock edges.
module clk_gen_sequencer #(
  parameter int COUNTER_WIDTH = clks_alot_p::COUNTER_WIDTH,
  parameter int MIN_HALF_RATE = clks_alot_p::MIN_HALF_RATE,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  common_p::clk_dom_s         sys_dom_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic [COUNTER_WIDTH-1:0]   cfg_high_half_i,
  input  logic [COUNTER_WIDTH-1:0]   cfg_low_half_i,
  input  logic [COUNTER_WIDTH-1:0]   cfg_preempt_lead_i,
  input  logic                       cfg_polarity_i,
  output logic                       cfg_err_o,
  input  logic                       gen_busy_i,
  input  logic                       gen_edge_i,
  input  logic                       gen_level_i,
  output logic                       set_polarity_o,
  output logic                       starting_polarity_o,
  output logic                       generation_en_o,
  output logic [COUNTER_WIDTH-1:0]   expected_half_rate_minus_two_o,
  output logic [COUNTER_WIDTH-1:0]   expected_quarter_rate_minus_one_o,
  output logic [COUNTER_WIDTH-1:0]   preemptive_half_rate_minus_one_o,
  output logic [COUNTER_WIDTH-1:0]   preemptive_quarter_rate_minus_one_o,
  output logic                       running_o,
  output logic                       drain_timeout_o
);

  import clks_alot_p::*;

  localparam int DrainW = $clog2(DRAIN_TIMEOUT);

  seq_state_e        state_q, state_d;
  rate_cfg_s         activeCfg_q, activeCfg_d;
  rate_cfg_s         shadowCfg_q, shadowCfg_d;
  rate_cfg_s         offered;
  logic              shadowPending_q, shadowPending_d;
  logic [DrainW-1:0] drainCnt_q, drainCnt_d;
  logic              drainTimeout_q, drainTimeout_d;
  logic              cfgErr_q, cfgErr_d;
  logic              setPolarity_q, startPolarity_q, genEn_q, running_q;
  logic              cfgLegal, cfgReady, handshake, armEntry;
  logic              deriveLoad, deriveLevel;

  // The operand block is fed the next-state config so a shadow swap and its operands land together.
  always_comb begin
    offered.high_half    = cfg_high_half_i;
    offered.low_half     = cfg_low_half_i;
    offered.preempt_lead = cfg_preempt_lead_i;
    offered.polarity     = cfg_polarity_i;
    cfgLegal  = cfg_legal(offered, COUNTER_WIDTH'(MIN_HALF_RATE));
    cfgReady  = ((state_q == IDLE) || (state_q == RUN)) && !shadowPending_q;
    handshake = cfg_valid_i && cfgReady;

    state_d         = state_q;
    activeCfg_d     = activeCfg_q;
    shadowCfg_d     = shadowCfg_q;
    shadowPending_d = shadowPending_q;
    drainCnt_d      = drainCnt_q;
    drainTimeout_d  = drainTimeout_q;
    cfgErr_d        = handshake && !cfgLegal;
    deriveLoad      = 1'b0;
    deriveLevel     = gen_level_i;

    unique case (state_q)
      IDLE: begin
        if (handshake && cfgLegal) activeCfg_d = offered;
        if (start_i) begin
          drainTimeout_d = 1'b0;
          if (activeCfg_q.high_half != '0) begin
            state_d = ARM;
            if (shadowPending_q) begin
              activeCfg_d     = shadowCfg_q;
              shadowPending_d = 1'b0;
            end
            deriveLoad  = 1'b1;
            deriveLevel = activeCfg_d.polarity;
          end else begin
            cfgErr_d = 1'b1;
          end
        end
      end
      ARM: state_d = RUN;
      RUN: begin
        if (handshake && cfgLegal) begin
          shadowCfg_d     = offered;
          shadowPending_d = 1'b1;
        end
        if (stop_i) begin
          state_d    = DRAIN;
          drainCnt_d = '0;
        end else if (gen_edge_i) begin
          deriveLoad = 1'b1;
          if (shadowPending_q) begin
            activeCfg_d     = shadowCfg_q;
            shadowPending_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (!gen_busy_i) begin
          state_d = IDLE;
        end else if (drainCnt_q == DrainW'(DRAIN_TIMEOUT - 1)) begin
          state_d        = IDLE;
          drainTimeout_d = 1'b1;
        end else begin
          drainCnt_d = drainCnt_q + DrainW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    armEntry = (state_q == IDLE) && (state_d == ARM);
  end

  always_ff @(posedge sys_dom_i.clk) begin
    if (!sys_dom_i.rst_n) begin
      state_q         <= IDLE;
      activeCfg_q     <= '0;
      shadowCfg_q     <= '0;
      shadowPending_q <= 1'b0;
      drainCnt_q      <= '0;
      drainTimeout_q  <= 1'b0;
      cfgErr_q        <= 1'b0;
      setPolarity_q   <= 1'b0;
      startPolarity_q <= 1'b0;
      genEn_q         <= 1'b0;
      running_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      activeCfg_q     <= activeCfg_d;
      shadowCfg_q     <= shadowCfg_d;
      shadowPending_q <= shadowPending_d;
      drainCnt_q      <= drainCnt_d;
      drainTimeout_q  <= drainTimeout_d;
      cfgErr_q        <= cfgErr_d;
      setPolarity_q   <= armEntry;
      if (armEntry) startPolarity_q <= activeCfg_d.polarity;
      genEn_q         <= (state_d == RUN);
      running_q       <= (state_d == RUN);
    end
  end

  clk_rate_derive uDerive (
    .clk_i                               (sys_dom_i.clk),
    .rst_ni                              (sys_dom_i.rst_n),
    .load_i                              (deriveLoad),
    .level_i                             (deriveLevel),
    .cfg_i                               (activeCfg_d),
    .expected_half_rate_minus_two_o      (expected_half_rate_minus_two_o),
    .expected_quarter_rate_minus_one_o   (expected_quarter_rate_minus_one_o),
    .preemptive_half_rate_minus_one_o    (preemptive_half_rate_minus_one_o),
    .preemptive_quarter_rate_minus_one_o (preemptive_quarter_rate_minus_one_o)
  );

  assign cfg_ready_o         = cfgReady;
  assign cfg_err_o           = cfgErr_q;
  assign set_polarity_o      = setPolarity_q;
  assign starting_polarity_o = startPolarity_q;
  assign generation_en_o     = genEn_q;
  assign running_o           = running_q;
  assign drain_timeout_o     = drainTimeout_q;

endmodule

// File: tb/tb_clk_gen_sequencer.sv
// Directed vector bench for clk_gen_sequencer: one table row per clock, plus drain-timeout and reset sequences.
module tb_clk_gen_sequencer;

  localparam int W = clks_alot_p::COUNTER_WIDTH;

  typedef struct packed {
    logic rstN, start, stop, cfgValid;
    logic [W-1:0] high, low, lead;
    logic pol, busy, genEdge, level;
  } stim_t;

  typedef struct packed {
    logic ready, err, setPol, startPol, en, running, timeout;
    logic [W-1:0] eh, eq, ph, pq;
  } resp_t;

  typedef struct {
    string name;
    stim_t s;
    resp_t r;
  } vec_t;

  logic clk = 1'b0;
  logic rstN, start, stop, cfgValid, pol, busy, genEdge, level;
  logic [W-1:0] high, low, lead;
  common_p::clk_dom_s sysDom;
  logic cfgReady, cfgErr, setPol, startPol, genEn, running, drainTo;
  logic [W-1:0] opEh, opEq, opPh, opPq;

  int vecCount = 0;
  int missCount = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;
  assign sysDom = {clk, rstN};

  clk_gen_sequencer dut (
    .sys_dom_i                           (sysDom),
    .start_i                             (start),
    .stop_i                              (stop),
    .cfg_valid_i                         (cfgValid),
    .cfg_ready_o                         (cfgReady),
    .cfg_high_half_i                     (high),
    .cfg_low_half_i                      (low),
    .cfg_preempt_lead_i                  (lead),
    .cfg_polarity_i                      (pol),
    .cfg_err_o                           (cfgErr),
    .gen_busy_i                          (busy),
    .gen_edge_i                          (genEdge),
    .gen_level_i                         (level),
    .set_polarity_o                      (setPol),
    .starting_polarity_o                 (startPol),
    .generation_en_o                     (genEn),
    .expected_half_rate_minus_two_o      (opEh),
    .expected_quarter_rate_minus_one_o   (opEq),
    .preemptive_half_rate_minus_one_o    (opPh),
    .preemptive_quarter_rate_minus_one_o (opPq),
    .running_o                           (running),
    .drain_timeout_o                     (drainTo)
  );

  function automatic stim_t S(input int r, input int st, input int sp, input int cv, input int hi,
                              input int lo, input int ld, input int pl, input int bz, input int ed,
                              input int lv);
    stim_t s;
    s.rstN = r[0]; s.start = st[0]; s.stop = sp[0]; s.cfgValid = cv[0];
    s.high = W'(hi); s.low = W'(lo); s.lead = W'(ld);
    s.pol = pl[0]; s.busy = bz[0]; s.genEdge = ed[0]; s.level = lv[0];
    return s;
  endfunction

  function automatic resp_t R(input int rd, input int er, input int sp, input int spl, input int en,
                              input int rn, input int to, input int eh, input int eq, input int ph,
                              input int pq);
    resp_t r;
    r.ready = rd[0]; r.err = er[0]; r.setPol = sp[0]; r.startPol = spl[0];
    r.en = en[0]; r.running = rn[0]; r.timeout = to[0];
    r.eh = W'(eh); r.eq = W'(eq); r.ph = W'(ph); r.pq = W'(pq);
    return r;
  endfunction

  task automatic addVec(input string n, input stim_t s, input resp_t r);
    vec_t v;
    v.name = n; v.s = s; v.r = r;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input stim_t s);
    rstN = s.rstN; start = s.start; stop = s.stop; cfgValid = s.cfgValid;
    high = s.high; low = s.low; lead = s.lead; pol = s.pol;
    busy = s.busy; genEdge = s.genEdge; level = s.level;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string n, input resp_t exp);
    resp_t got;
    got.ready = cfgReady; got.err = cfgErr; got.setPol = setPol; got.startPol = startPol;
    got.en = genEn; got.running = running; got.timeout = drainTo;
    got.eh = opEh; got.eq = opEq; got.ph = opPh; got.pq = opPq;
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got rdy=%b err=%b sp=%b pol=%b en=%b run=%b to=%b ops=%0d/%0d/%0d/%0d, want rdy=%b err=%b sp=%b pol=%b en=%b run=%b to=%b ops=%0d/%0d/%0d/%0d",
               n, got.ready, got.err, got.setPol, got.startPol, got.en, got.running, got.timeout,
               got.eh, got.eq, got.ph, got.pq, exp.ready, exp.err, exp.setPol, exp.startPol,
               exp.en, exp.running, exp.timeout, exp.eh, exp.eq, exp.pq == exp.pq ? exp.ph : exp.ph, exp.pq);
    end
  endtask

  initial begin
    int drainCycles;

    // Each row: inputs held for one clock, outputs expected just after that edge.
    //                                rst st sp cv  hi  lo ld pl bz ed lv     rd er sp spl en rn to eh eq ph pq
    addVec("reset",          S(0, 0, 0, 0,  0,  0, 0, 0, 1, 0, 0), R(1, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0));
    addVec("startNoCfg",     S(1, 1, 0, 0,  0,  0, 0, 0, 1, 0, 0), R(1, 1, 0, 0, 0, 0, 0,  0, 0,  0, 0));
    addVec("errPulseEnds",   S(1, 0, 0, 0,  0,  0, 0, 0, 1, 0, 0), R(1, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0));
    addVec("idleHighTooLow", S(1, 0, 0, 1,  3, 10, 0, 0, 1, 0, 0), R(1, 1, 0, 0, 0, 0, 0,  0, 0,  0, 0));
    addVec("idleCfgLegal",   S(1, 0, 0, 1, 10, 10, 2, 0, 1, 0, 0), R(1, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0));
    addVec("startToArm",     S(1, 1, 0, 0,  0,  0, 0, 0, 1, 0, 0), R(0, 0, 1, 0, 0, 0, 0,  8, 4,  9, 2));
    addVec("armToRun",       S(1, 0, 0, 0,  0,  0, 0, 0, 1, 0, 0), R(1, 0, 0, 0, 1, 1, 0,  8, 4,  9, 2));
    addVec("cfgWithEdge",    S(1, 0, 0, 1, 12,  6, 1, 0, 1, 1, 1), R(0, 0, 0, 0, 1, 1, 0,  8, 4,  9, 2));
    addVec("shadowOnHigh",   S(1, 0, 0, 0,  0,  0, 0, 0, 1, 1, 1), R(1, 0, 0, 0, 1, 1, 0, 10, 5, 11, 4));
    addVec("edgeToLow",      S(1, 0, 0, 0,  0,  0, 0, 0, 1, 1, 0), R(1, 0, 0, 0, 1, 1, 0,  4, 2,  5, 1));
    addVec("leadAtLimit",    S(1, 0, 0, 1, 10, 10, 5, 0, 1, 0, 0), R(1, 1, 0, 0, 1, 1, 0,  4, 2,  5, 1));
    addVec("errClears",      S(1, 0, 0, 0,  0,  0, 0, 0, 1, 0, 0), R(1, 0, 0, 0, 1, 1, 0,  4, 2,  5, 1));
    addVec("runHighTooLow",  S(1, 0, 0, 1,  3, 10, 0, 0, 1, 0, 0), R(1, 1, 0, 0, 1, 1, 0,  4, 2,  5, 1));
    addVec("activeKept",     S(1, 0, 0, 0,  0,  0, 0, 0, 1, 1, 1), R(1, 0, 0, 0, 1, 1, 0, 10, 5, 11, 4));
    addVec("leadJustLegal",  S(1, 0, 0, 1, 10, 10, 4, 1, 1, 0, 0), R(0, 0, 0, 0, 1, 1, 0, 10, 5, 11, 4));
    addVec("stopBeatsEdge",  S(1, 0, 1, 0,  0,  0, 0, 0, 1, 1, 0), R(0, 0, 0, 0, 0, 0, 0, 10, 5, 11, 4));
    addVec("drainFrozen",    S(1, 1, 0, 0,  0,  0, 0, 0, 1, 1, 0), R(0, 0, 0, 0, 0, 0, 0, 10, 5, 11, 4));
    addVec("busyFalls",      S(1, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0), R(0, 0, 0, 0, 0, 0, 0, 10, 5, 11, 4));
    addVec("pendingBlocks",  S(1, 0, 0, 1, 20, 20, 0, 0, 0, 0, 0), R(0, 0, 0, 0, 0, 0, 0, 10, 5, 11, 4));
    addVec("armAppliesShad", S(1, 1, 1, 0,  0,  0, 0, 0, 0, 0, 0), R(0, 0, 1, 1, 0, 0, 0,  8, 4,  9, 0));
    addVec("runWithPol1",    S(1, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0), R(1, 0, 0, 1, 1, 1, 0,  8, 4,  9, 0));
    addVec("startIgnored",   S(1, 1, 0, 0,  0,  0, 0, 0, 0, 0, 0), R(1, 0, 0, 1, 1, 1, 0,  8, 4,  9, 0));

    applyStimulus(S(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tick();
    tick();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s);
      tick();
      checkOutput(vecs[i].name, vecs[i].r);
    end

    // Busy never falls: the drain must give up after exactly DRAIN_TIMEOUT cycles.
    applyStimulus(S(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    tick();
    checkOutput("stopToDrain", R(0, 0, 0, 1, 0, 0, 0, 8, 4, 9, 0));
    applyStimulus(S(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    drainCycles = 0;
    for (int i = 1; i <= 2000; i++) begin
      tick();
      if (drainTo) begin
        drainCycles = i;
        break;
      end
    end
    vecCount++;
    if (drainCycles != 1024) begin
      missCount++;
      $display("[TB] FAIL drainTimeoutCycles: got %0d cycles, want %0d", drainCycles, 1024);
    end
    checkOutput("drainTimeout", R(1, 0, 0, 1, 0, 0, 1, 8, 4, 9, 0));

    applyStimulus(S(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    checkOutput("startClearsTo", R(0, 0, 1, 1, 0, 0, 0, 8, 4, 9, 0));
    applyStimulus(S(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    checkOutput("runAgain", R(1, 0, 0, 1, 1, 1, 0, 8, 4, 9, 0));

    applyStimulus(S(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tick();
    checkOutput("resetMidRun", R(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
